// File: rtl/apb_slave_pkg.sv
// Shared APB definitions: bus width, slave FSM state encoding and the
// per-slave base addresses used by the bridge address decoder.
package apb_slave_pkg;

    localparam int APB_WIDTH = 32;
    localparam int WCNT_W    = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [APB_WIDTH-1:0] SLV0_BASE_ADDR = 32'h8000_0000;
    localparam logic [APB_WIDTH-1:0] SLV1_BASE_ADDR = 32'h8000_1000;
    localparam logic [APB_WIDTH-1:0] SLV2_BASE_ADDR = 32'h8000_2000;
    localparam logic [APB_WIDTH-1:0] SLV3_BASE_ADDR = 32'h8000_3000;

endpackage

// File: rtl/apb_slave_mem.sv
// Word storage for the APB slave: synchronous write, combinational read,
// synchronous clear of every word.
module apb_slave_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is cleared here only because the slave must read back
    // zeros after reset; plain storage arrays normally carry no reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave.sv
// APB completer with WAIT programmable wait states, address/alignment error
// reporting on Pslverr and a sticky protocol-violation flag.
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int                   WIDTH     = APB_WIDTH,
    parameter int                   DEPTH     = 16,
    parameter int                   WAIT      = 0,
    parameter logic [WIDTH-1:0]     BASE_ADDR = 32'h8000_0000
) (
    input  logic             Hclk,
    input  logic             Hreset,
    input  logic             Psel,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [WIDTH-1:0] Paddr,
    input  logic [WIDTH-1:0] Pwdata,
    output logic [WIDTH-1:0] Prdata,
    output logic             Pready,
    output logic             Pslverr,
    output logic             Proto_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (WIDTH + 1)'(4 * DEPTH);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               proto_q, proto_d;
    logic               setup;
    logic               addr_err;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [WIDTH-1:0]   rd_word;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            proto_q <= proto_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        proto_d = proto_q;
        setup   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Psel && !Penable) begin
                    setup = 1'b1;
                end else if (Psel && Penable) begin
                    proto_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!Psel) begin
                    proto_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (!Penable) begin
                    // Setup while a transfer is open: drop it and restart.
                    proto_d = 1'b1;
                    setup   = 1'b1;
                end else begin
                    if ((Paddr != addr_q) || (Pwrite != wr_q) || (wr_q && (Pwdata != wdata_q))) begin
                        proto_d = 1'b1;
                    end
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (setup) begin
            addr_d  = Paddr;
            wr_d    = Pwrite;
            wdata_d = Pwdata;
            wcnt_d  = WCNT_W'(WAIT);
            state_d = ST_ACCESS;
        end
    end

    assign addr_err = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= LIMIT) || (addr_q[1:0] != 2'b00);
    assign mem_idx  = IDX_W'((addr_q - BASE_ADDR) >> 2);

    assign Pready    = (state_q == ST_ACCESS) && Psel && Penable && (wcnt_q == '0);
    assign Pslverr   = Pready && addr_err;
    assign Proto_err = proto_q;
    assign mem_we    = Pready && wr_q && !addr_err && !Hreset;
    assign Prdata    = (Pready && !wr_q && !addr_err) ? rd_word : '0;

    apb_slave_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (Hclk),
        .clr   (Hreset),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (wdata_q),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: three instances (WAIT = 0, 2, 3) on one
// shared bus, scored against a word-array model of the slave behaviour.
module tb_apb_slave;

    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam int          NWORDS   = 16;
    localparam int          MAX_WAIT = 40;

    logic        hclk;
    logic        hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [2:0]  proto_err;

    int errors = 0;
    int checks = 0;

    // Reference model: storage words, configured wait states per instance.
    logic [31:0] model_mem [3][NWORDS];
    int          wait_cfg  [3] = '{0, 2, 3};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave #(
            .WIDTH     (32),
            .DEPTH     (NWORDS),
            .WAIT      (g + ((g > 0) ? 1 : 0)),
            .BASE_ADDR (BASE)
        ) dut (
            .Hclk      (hclk),
            .Hreset    (hreset),
            .Psel      (psel[g]),
            .Penable   (penable),
            .Pwrite    (pwrite),
            .Paddr     (paddr),
            .Pwdata    (pwdata),
            .Prdata    (prdata[g]),
            .Pready    (pready[g]),
            .Pslverr   (pslverr[g]),
            .Proto_err (proto_err[g])
        );
    end

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic model_err(input logic [31:0] a);
        return (a < BASE) || (a >= BASE + 32'(4 * NWORDS)) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        logic [31:0] off;
        if (model_err(a)) return 32'h0;
        off = (a - BASE) >> 2;
        return model_mem[k][off[3:0]];
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
        if (r == 1) return BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + 32'($urandom_range(1, 3));
        return BASE + 32'(4 * $urandom_range(0, NWORDS + 3));
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        if (!model_err(a)) begin
            off = (a - BASE) >> 2;
            model_mem[k][off[3:0]] = d;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NWORDS; i++)
                model_mem[k][i] = 32'h0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the completing
    // edge, so consecutive calls are back to back with no idle bubble.
    task automatic do_xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int waits, output logic [31:0] rd, output logic err);
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        waits   = 0;
        rd      = 32'h0;
        err     = 1'b0;
        while (1) begin
            @(negedge hclk);
            if (pready[k]) begin
                rd  = prdata[k];
                err = pslverr[k];
                @(posedge hclk); #1;
                break;
            end
            waits++;
            if (waits > MAX_WAIT) begin
                @(posedge hclk); #1;
                break;
            end
            @(posedge hclk); #1;
        end
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        hreset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        @(posedge hclk); #1;
        hreset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge hclk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0 || proto_err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: pready=%b pslverr=%b prdata=%h proto=%b, want all 0",
                         k, pready[k], pslverr[k], prdata[k], proto_err[k]);
            end
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_basic();
        int w; logic [31:0] rd; logic e;
        do_xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, w, rd, e);
        model_write(0, 32'h8000_0004, 32'hDEAD_BEEF);
        checks++;
        if (w !== 0 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: waits=%0d err=%b, want waits=0 err=0", w, e);
        end
        do_xfer(0, 1'b0, 32'h8000_0004, 32'h0, w, rd, e);
        checks++;
        if (w !== 0 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_read: waits=%0d err=%b data=%h, want 0/0/deadbeef", w, e, rd);
        end
    endtask

    task automatic test_wait();
        int w; logic [31:0] rd; logic e;
        do_xfer(1, 1'b0, 32'h8000_0000, 32'h0, w, rd, e);
        checks++;
        if (w !== 2 || e !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL wait2_read: waits=%0d err=%b data=%h, want 2/0/00000000", w, e, rd);
        end
    endtask

    task automatic test_out_of_range();
        int w; logic [31:0] rd; logic e;
        do_xfer(0, 1'b1, 32'h8000_0040, 32'h1234_5678, w, rd, e);
        checks++;
        if (w !== 0 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_write: waits=%0d err=%b, want waits=0 err=1", w, e);
        end
        do_xfer(0, 1'b0, 32'h8000_0040, 32'h0, w, rd, e);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: err=%b data=%h, want err=1 data=0", e, rd);
        end
        for (int i = 0; i < NWORDS; i++) begin
            do_xfer(0, 1'b0, BASE + 32'(4 * i), 32'h0, w, rd, e);
            checks++;
            if (e !== 1'b0 || rd !== model_read(0, BASE + 32'(4 * i))) begin
                errors++;
                $display("FAIL oor_word%0d: err=%b data=%h, want err=0 data=%h",
                         i, e, rd, model_read(0, BASE + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_misaligned();
        int w; logic [31:0] rd; logic e;
        do_xfer(0, 1'b1, 32'h8000_0002, 32'hCAFE_F00D, w, rd, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_write: err=%b, want 1", e);
        end
        do_xfer(0, 1'b0, 32'h8000_0000, 32'h0, w, rd, e);
        checks++;
        if (e !== 1'b0 || rd !== model_read(0, 32'h8000_0000)) begin
            errors++;
            $display("FAIL misaligned_word0: err=%b data=%h, want err=0 data=%h",
                     e, rd, model_read(0, 32'h8000_0000));
        end
    endtask

    task automatic test_back_to_back();
        int w; logic [31:0] rd; logic e; logic wr; logic [31:0] a; logic [31:0] d; int k;
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            a  = rand_addr();
            d  = $urandom;
            do_xfer(k, wr, a, d, w, rd, e);
            checks++;
            if (w !== wait_cfg[k] || e !== model_err(a) || rd !== (wr ? 32'h0 : model_read(k, a))) begin
                errors++;
                $display("FAIL b2b_%0d inst%0d %s @%h: waits=%0d err=%b data=%h, want %0d/%b/%h",
                         n, k, wr ? "wr" : "rd", a, w, e, rd, wait_cfg[k], model_err(a),
                         wr ? 32'h0 : model_read(k, a));
            end
            if (wr) model_write(k, a, d);
        end
        checks++;
        if (proto_err !== 3'b000) begin
            errors++;
            $display("FAIL b2b_proto: proto_err=%b, want 000", proto_err);
        end
    endtask

    task automatic test_abort();
        int w; logic [31:0] rd; logic e;
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0010;
        pwdata  = 32'h0BAD_0BAD;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        psel    = '0;
        penable = 1'b0;
        @(posedge hclk); #1;
        checks++;
        if (proto_err[1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_proto: proto_err=%b, want 1", proto_err[1]);
        end
        do_xfer(1, 1'b0, 32'h8000_0010, 32'h0, w, rd, e);
        checks++;
        if (w !== 2 || e !== 1'b0 || rd !== model_read(1, 32'h8000_0010)) begin
            errors++;
            $display("FAIL abort_nowrite: waits=%0d err=%b data=%h, want 2/0/%h",
                     w, e, rd, model_read(1, 32'h8000_0010));
        end
        do_reset();
    endtask

    task automatic test_proto_err();
        int w; logic [31:0] rd; logic e; logic [31:0] a; logic [31:0] d; logic wr;
        psel    = 3'b100;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = BASE;
        @(negedge hclk);
        checks++;
        if (pready[2] !== 1'b0) begin
            errors++;
            $display("FAIL proto_noready: pready=%b, want 0", pready[2]);
        end
        @(posedge hclk); #1;
        psel    = '0;
        penable = 1'b0;
        @(negedge hclk);
        checks++;
        if (proto_err !== 3'b100) begin
            errors++;
            $display("FAIL proto_set: proto_err=%b, want 100", proto_err);
        end
        @(posedge hclk); #1;
        for (int n = 0; n < 10; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
            d  = $urandom;
            do_xfer(2, wr, a, d, w, rd, e);
            checks++;
            if (w !== 3 || e !== 1'b0 || rd !== (wr ? 32'h0 : model_read(2, a)) || proto_err[2] !== 1'b1) begin
                errors++;
                $display("FAIL proto_hold_%0d: waits=%0d err=%b data=%h proto=%b, want 3/0/%h/1",
                         n, w, e, rd, proto_err[2], wr ? 32'h0 : model_read(2, a));
            end
            if (wr) model_write(2, a, d);
        end
        do_reset();
        @(negedge hclk);
        checks++;
        if (proto_err !== 3'b000) begin
            errors++;
            $display("FAIL proto_clear: proto_err=%b, want 000", proto_err);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] rd; logic e;
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0008;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge hclk); #1;
            @(negedge hclk);
            checks++;
            if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_ready%0d: pready=%b pslverr=%b, want 0/0", c, pready[2], pslverr[2]);
            end
        end
        @(posedge hclk); #1;
        hreset  = 1'b0;
        psel    = '0;
        penable = 1'b0;
        model_clear();
        do_xfer(2, 1'b0, 32'h8000_0008, 32'h0, w, rd, e);
        checks++;
        if (w !== 3 || e !== 1'b0 || rd !== 32'h0 || proto_err[2] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_read: waits=%0d err=%b data=%h proto=%b, want 3/0/00000000/0",
                     w, e, rd, proto_err[2]);
        end
    endtask

    initial begin
        hreset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_clear();
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;

        test_reset();
        test_basic();
        test_wait();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_abort();
        test_proto_err();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 The block SHALL have parameter WIDTH, default `WIDTH (32), APB address/data width.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of WIDTH-bit storage words.
REQ-003 The block SHALL have parameter WAIT, default 0, range 0..15, wait cycles inserted per transfer.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 The block SHALL have port Hclk, input, 1, the single clock, with all logic on its rising edge.
REQ-006 The block SHALL have port Hreset, input, 1, a synchronous, active-high reset.
REQ-007 The block SHALL have port Psel, input, 1, the select line for this slave (one bit of the bridge Pselx).
REQ-008 The block SHALL have port Penable, input, 1, the APB access-phase strobe.
REQ-009 The block SHALL have port Pwrite, input, 1, where 1 means write and 0 means read.
REQ-010 The block SHALL have port Paddr, input, WIDTH, the byte address.
REQ-011 The block SHALL have port Pwdata, input, WIDTH, the write data.
REQ-012 The block SHALL have port Prdata, output, WIDTH, the read data.
REQ-013 The block SHALL have port Pready, output, 1, the transfer-complete signal.
REQ-014 The block SHALL have port Pslverr, output, 1, the transfer error, valid only while Pready=1.
REQ-015 The block SHALL have port Proto_err, output, 1, a sticky APB protocol-violation flag.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and ACCESS, plus a 4-bit wait counter wcnt.
REQ-017 In IDLE with Psel=1 and Penable=0 (setup), the block SHALL latch Paddr, Pwrite and Pwdata, load wcnt=WAIT and go to ACCESS.
REQ-018 In IDLE with Psel=1 and Penable=1, the block SHALL set Proto_err, perform no transfer and stay in IDLE.
REQ-019 In ACCESS with Psel=1, Penable=1 and wcnt!=0, the block SHALL decrement wcnt and hold Pready=0.
REQ-020 In ACCESS with Psel=1, Penable=1 and wcnt=0, Pready SHALL be 1 (combinational from state/wcnt), the transfer SHALL complete that cycle, and the next state SHALL be IDLE.
REQ-021 Access latency SHALL be WAIT+1 cycles after the setup cycle, with no idle bubble required between back-to-back transfers beyond the mandatory APB setup cycle.
REQ-022 In ACCESS with Psel=0, the block SHALL set Proto_err, abort with no memory change, and go to IDLE.
REQ-023 In ACCESS with Psel=1 and Penable=0, the block SHALL set Proto_err, abort the old transfer, and treat the cycle as a new setup per REQ-017.
REQ-024 A change of Paddr or Pwrite during ACCESS, or of Pwdata during a write ACCESS, SHALL set Proto_err, and the transfer SHALL use the latched values.
REQ-025 An address error SHALL exist when the latched address is below BASE_ADDR, at or above BASE_ADDR+4*DEPTH, or has Paddr[1:0]!=0.
REQ-026 Pslverr SHALL equal Pready AND address-error, and SHALL be 0 whenever Pready=0.
REQ-027 A write completing without error SHALL update word (addr-BASE_ADDR)>>2 at that clock edge, and an erroring write SHALL change nothing.
REQ-028 Prdata SHALL be the addressed word when Pready=1, read=1 and there is no error, and SHALL be 0 otherwise, including for erroring reads.
REQ-029 Proto_err SHALL stay at 1 until reset, with no other clearing mechanism.

Reset
REQ-030 With Hreset=1 at a clock edge, the block SHALL force state IDLE, wcnt=0, all storage words=0 and Proto_err=0, so that Prdata=0, Pready=0 and Pslverr=0 from the following cycle.
REQ-031 Reset SHALL dominate all simultaneous bus activity, and a transfer in progress at reset SHALL be dropped with no write performed.

Structure
REQ-032 The shared definitions file SHALL hold WIDTH, the IDLE/ACCESS state encodings and the per-slave BASE_ADDR constants used by the bridge decoder.
REQ-033 Storage SHALL be a single sub-module, apb_slave_mem, with a synchronous write, a combinational read and a synchronous clear, while the FSM, counter and error logic remain in apb_slave.

Verification
REQ-034 The bench SHALL cover: WAIT=0, write 32'hDEADBEEF to 32'h8000_0004, then read it -> Pready=1 in the first access cycle of each transfer, Prdata=32'hDEADBEEF, Pslverr=0.
REQ-035 The bench SHALL cover: WAIT=2, read 32'h8000_0000 -> Pready=0 for 2 access cycles and 1 on the 3rd, Prdata=0 after reset.
REQ-036 The bench SHALL cover: DEPTH=16, write 32'h1234_5678 to 32'h8000_0040 then read it -> Pslverr=1 on both, Prdata=0, all words unchanged.
REQ-037 The bench SHALL cover: write to misaligned 32'h8000_0002 -> Pslverr=1, word 0 unchanged.
REQ-038 The bench SHALL cover: Psel=1 and Penable=1 with no setup cycle -> Proto_err=1 next cycle and held through 10 later legal transfers until Hreset.
REQ-039 The bench SHALL cover: WAIT=3, assert Hreset in the 2nd access cycle of a write of 32'hA5A5A5A5 to 32'h8000_0008 -> next cycle Pready=0 and state IDLE; a following read of 32'h8000_0008 returns 0.
